// File: rtl/deser_arbiter.sv
// Round-robin arbiter that lends one serial deserializer to N_CH sources, one word at a time,
// tags each finished word with its channel, and flushes the deserializer on stalled or abandoned words.
module deser_arbiter #(
  parameter int N_CH    = 4,
  parameter int WORD_W  = 16,
  parameter int TIMEOUT = 64
) (
  input  logic                    clk_i,
  input  logic                    rst_n_i,
  input  logic [N_CH-1:0]         ch_req_i,
  input  logic [N_CH-1:0]         ch_data_i,
  input  logic [N_CH-1:0]         ch_data_val_i,
  output logic [N_CH-1:0]         ch_gnt_o,
  output logic                    deser_srst_o,
  output logic                    deser_data_o,
  output logic                    deser_data_val_o,
  input  logic                    deser_word_val_i,
  output logic [$clog2(N_CH)-1:0] word_ch_o,
  output logic                    word_ch_val_o,
  output logic                    abort_o
);

  localparam int CH_W = $clog2(N_CH);
  localparam int BC_W = $clog2(WORD_W + 1);
  localparam int IC_W = $clog2(TIMEOUT + 1);

  typedef enum logic [1:0] {IDLE, GRANT, WAIT_WORD, FLUSH} state_t;

  state_t          state;
  logic [CH_W-1:0] rr_ptr;
  logic [BC_W-1:0] bit_cnt;
  logic [IC_W-1:0] idle_cnt;

  logic [2*N_CH-1:0] req_rot;
  logic              pick_found;
  logic [CH_W-1:0]   pick_off;
  logic [CH_W:0]     pick_sum;
  logic [CH_W-1:0]   pick_idx;
  logic [CH_W-1:0]   next_rr;
  logic              owner_req;
  logic              owner_val;
  logic              idle_expired;

  // Rotate the requests so that rr_ptr sits at bit 0; the lowest set bit is the winner.
  assign req_rot = {ch_req_i, ch_req_i} >> rr_ptr;

  always_comb begin
    pick_found = 1'b0;
    pick_off   = '0;
    for (int i = N_CH - 1; i >= 0; i--) begin
      if (req_rot[i]) begin
        pick_found = 1'b1;
        pick_off   = CH_W'(i);
      end
    end
  end

  assign pick_sum = {1'b0, rr_ptr} + {1'b0, pick_off};
  assign pick_idx = (pick_sum >= (CH_W+1)'(N_CH)) ? CH_W'(pick_sum - (CH_W+1)'(N_CH))
                                                  : CH_W'(pick_sum);
  assign next_rr  = (pick_idx == CH_W'(N_CH - 1)) ? '0 : pick_idx + CH_W'(1);

  assign owner_req    = ch_req_i[word_ch_o];
  assign owner_val    = ch_data_val_i[word_ch_o];
  assign idle_expired = (idle_cnt == IC_W'(TIMEOUT - 1));

  assign deser_data_o     = (state == GRANT) & ch_data_i[word_ch_o];
  assign deser_data_val_o = (state == GRANT) & owner_val;
  assign word_ch_val_o    = (state == WAIT_WORD) & deser_word_val_i;

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      state        <= FLUSH;
      ch_gnt_o     <= '0;
      deser_srst_o <= 1'b1;
      abort_o      <= 1'b0;
      word_ch_o    <= '0;
      rr_ptr       <= '0;
      bit_cnt      <= '0;
      idle_cnt     <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (pick_found) begin
            ch_gnt_o  <= N_CH'(1) << pick_idx;
            word_ch_o <= pick_idx;
            rr_ptr    <= next_rr;
            bit_cnt   <= '0;
            idle_cnt  <= '0;
            state     <= GRANT;
          end
        end
        GRANT: begin
          if (!owner_req || (!owner_val && idle_expired)) begin
            ch_gnt_o     <= '0;
            deser_srst_o <= 1'b1;
            abort_o      <= 1'b1;
            bit_cnt      <= '0;
            idle_cnt     <= '0;
            state        <= FLUSH;
          end else if (owner_val) begin
            idle_cnt <= '0;
            // The grant is released on the same edge that accepts the last bit.
            if (bit_cnt == BC_W'(WORD_W - 1)) begin
              ch_gnt_o <= '0;
              bit_cnt  <= '0;
              state    <= WAIT_WORD;
            end else begin
              bit_cnt <= bit_cnt + BC_W'(1);
            end
          end else begin
            idle_cnt <= idle_cnt + IC_W'(1);
          end
        end
        WAIT_WORD: begin
          if (deser_word_val_i) begin
            state <= IDLE;
          end else if (idle_expired) begin
            deser_srst_o <= 1'b1;
            abort_o      <= 1'b1;
            idle_cnt     <= '0;
            state        <= FLUSH;
          end else begin
            idle_cnt <= idle_cnt + IC_W'(1);
          end
        end
        FLUSH: begin
          deser_srst_o <= 1'b0;
          abort_o      <= 1'b0;
          bit_cnt      <= '0;
          idle_cnt     <= '0;
          state        <= IDLE;
        end
        default: state <= FLUSH;
      endcase
    end
  end

endmodule

// File: tb/tb_deser_arbiter.sv
// Bench for deser_arbiter: channel sources, a deserializer stand-in, a word-level reference model
// and a per-cycle compare, plus hand-computed checks on grant order, latencies and word contents.
module tb_deser_arbiter;

  localparam int N  = 4;
  localparam int W  = 16;
  localparam int TO = 64;
  localparam int CW = 2;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic [N-1:0]  ch_req = '0;
  logic [N-1:0]  ch_data = '0;
  logic [N-1:0]  ch_val = '0;
  logic [N-1:0]  ch_gnt;
  logic          srst, d_data, d_val;
  logic          word_val;
  logic [CW-1:0] word_ch;
  logic          tag_val, abort;

  always #5 clk = ~clk;

  deser_arbiter #(.N_CH(N), .WORD_W(W), .TIMEOUT(TO)) dut (
    .clk_i(clk), .rst_n_i(rst_n),
    .ch_req_i(ch_req), .ch_data_i(ch_data), .ch_data_val_i(ch_val),
    .ch_gnt_o(ch_gnt),
    .deser_srst_o(srst), .deser_data_o(d_data), .deser_data_val_o(d_val),
    .deser_word_val_i(word_val),
    .word_ch_o(word_ch), .word_ch_val_o(tag_val), .abort_o(abort)
  );

  int tests = 0;
  int fails = 0;

  task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
    tests++;
    if (actual !== expected) begin
      fails++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, actual, expected, $time);
    end
  endtask

  // Deserializer stand-in: shifts LSB-first, raises word valid stub_lat cycles after the last bit.
  int           stub_lat = 1;
  bit           stub_mute = 1'b0;
  logic [W-1:0] stub_sh, stub_word;
  int           stub_cnt, stub_dly;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stub_sh <= '0; stub_word <= '0; stub_cnt <= 0; stub_dly <= 0; word_val <= 1'b0;
    end else if (srst) begin
      stub_sh <= '0; stub_cnt <= 0; stub_dly <= 0; word_val <= 1'b0;
    end else begin
      word_val <= (stub_dly == 1);
      if (stub_dly != 0) stub_dly <= stub_dly - 1;
      if (d_val) begin
        if (stub_cnt == W - 1) begin
          stub_word <= {d_data, stub_sh[W-1:1]};
          stub_sh   <= '0;
          stub_cnt  <= 0;
          if (!stub_mute) stub_dly <= stub_lat;
        end else begin
          stub_sh  <= {d_data, stub_sh[W-1:1]};
          stub_cnt <= stub_cnt + 1;
        end
      end
    end
  end

  // Channel sources: configured by the test, started by bumping start_req.
  logic [W-1:0] s_words [N][2];
  int s_nw [N], s_gap [N], s_drop [N], s_stall [N], start_req [N];
  int s_wi [N], s_idx [N], s_gc [N], seen [N];
  bit s_act [N];

  initial begin
    for (int c = 0; c < N; c++) begin
      s_nw[c] = 0; s_gap[c] = 1; s_drop[c] = -1; s_stall[c] = -1; start_req[c] = 0;
      s_words[c][0] = '0; s_words[c][1] = '0;
    end
  end

  always @(posedge clk) begin
    for (int c = 0; c < N; c++) begin
      if (s_act[c] && ch_gnt[c] && ch_val[c]) begin
        s_idx[c]++;
        if (s_idx[c] == W) begin
          s_idx[c] = 0;
          s_wi[c]++;
          if (s_wi[c] == s_nw[c]) s_act[c] = 1'b0;
        end
      end
    end
    #1;
    for (int c = 0; c < N; c++) begin
      if (seen[c] != start_req[c]) begin
        seen[c] = start_req[c];
        s_act[c] = 1'b1; s_idx[c] = 0; s_wi[c] = 0; s_gc[c] = 0;
      end
      if (!rst_n) s_act[c] = 1'b0;
      if (s_act[c] && abort && word_ch == CW'(c)) s_act[c] = 1'b0;
      if (s_act[c] && s_drop[c] >= 0 && s_idx[c] == s_drop[c]) s_act[c] = 1'b0;
      ch_req[c] = s_act[c];
      if (s_act[c] && ch_gnt[c]) begin
        if (s_stall[c] >= 0 && s_idx[c] >= s_stall[c]) begin
          ch_val[c] = 1'b0; ch_data[c] = 1'b0;
        end else begin
          ch_val[c]  = (s_gc[c] == 0);
          ch_data[c] = s_words[c][s_wi[c]][s_idx[c]];
          s_gc[c]    = (s_gc[c] + 1) % s_gap[c];
        end
      end else if (s_act[c]) begin
        ch_val[c]  = 1'($urandom_range(0, 1));
        ch_data[c] = 1'($urandom_range(0, 1));
      end else begin
        ch_val[c] = 1'b0; ch_data[c] = 1'b0;
      end
    end
  end

  // Reference model: who owns the deserializer, how far the word got, and what it must contain.
  function automatic int firstFrom(input logic [N-1:0] req, input int start);
    for (int k = 0; k < N; k++) if (req[(start + k) % N]) return (start + k) % N;
    return -1;
  endfunction

  bit           m_busy, m_wait, m_flush, m_abort;
  int           m_owner, m_bits, m_quiet, m_rr, m_tag;
  logic [W-1:0] m_acc, m_pend;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_busy <= 0; m_wait <= 0; m_flush <= 1; m_abort <= 0;
      m_owner <= 0; m_bits <= 0; m_quiet <= 0; m_rr <= 0; m_tag <= 0; m_acc <= '0;
    end else if (m_flush) begin
      m_flush <= 0; m_abort <= 0;
    end else if (m_busy) begin
      if (!ch_req[m_owner]) begin
        m_busy <= 0; m_flush <= 1; m_abort <= 1;
      end else if (ch_val[m_owner]) begin
        m_quiet <= 0;
        if (m_bits == W - 1) begin
          m_busy <= 0; m_wait <= 1; m_bits <= 0;
          m_pend <= m_acc | (W'(ch_data[m_owner]) << m_bits);
        end else begin
          m_acc  <= m_acc | (W'(ch_data[m_owner]) << m_bits);
          m_bits <= m_bits + 1;
        end
      end else if (m_quiet == TO - 1) begin
        m_busy <= 0; m_flush <= 1; m_abort <= 1;
      end else begin
        m_quiet <= m_quiet + 1;
      end
    end else if (m_wait) begin
      if (word_val) m_wait <= 0;
      else if (m_quiet == TO - 1) begin
        m_wait <= 0; m_flush <= 1; m_abort <= 1;
      end else m_quiet <= m_quiet + 1;
    end else if (ch_req != '0) begin
      m_owner <= firstFrom(ch_req, m_rr);
      m_tag   <= firstFrom(ch_req, m_rr);
      m_rr    <= (firstFrom(ch_req, m_rr) + 1) % N;
      m_busy  <= 1; m_bits <= 0; m_quiet <= 0; m_acc <= '0;
    end
  end

  // Event log written by the compare process, read by the directed tests.
  int cyc = 0;
  int n_gnt = 0, n_tag = 0, n_abort = 0;
  int gnt_log [64];
  int gnt_cyc [64];
  int tag_cyc, abort_cyc, last_tag_ch, last_abort_ch;

  task automatic compareLoop();
    logic [N-1:0] prev_gnt = '0;
    forever begin
      @(negedge clk);
      cyc++;
      checkOutput("gnt", 32'(ch_gnt), m_busy ? 32'(N'(1) << m_owner) : 32'd0);
      checkOutput("srst", 32'(srst), 32'(m_flush));
      checkOutput("abort", 32'(abort), 32'(m_abort));
      checkOutput("word_ch", 32'(word_ch), 32'(m_tag));
      checkOutput("data_val", 32'(d_val), 32'(m_busy && ch_val[m_owner]));
      if (m_busy) checkOutput("data", 32'(d_data), 32'(ch_data[m_owner]));
      checkOutput("tag_val", 32'(tag_val), 32'(m_wait && word_val));
      if (m_wait && word_val) checkOutput("word", 32'(stub_word), 32'(m_pend));
      if (ch_gnt != '0 && prev_gnt == '0 && n_gnt < 64) begin
        for (int k = 0; k < N; k++) if (ch_gnt[k]) gnt_log[n_gnt] = k;
        gnt_cyc[n_gnt] = cyc;
        n_gnt++;
      end
      prev_gnt = ch_gnt;
      if (tag_val) begin n_tag++; tag_cyc = cyc; last_tag_ch = int'(word_ch); end
      if (abort) begin n_abort++; abort_cyc = cyc; last_abort_ch = int'(word_ch); end
    end
  endtask

  task automatic applyStimulus(input int c, input logic [W-1:0] w0, input logic [W-1:0] w1,
                               input int nw, input int gap, input int drop, input int stall);
    s_words[c][0] = w0; s_words[c][1] = w1;
    s_nw[c] = nw; s_gap[c] = gap; s_drop[c] = drop; s_stall[c] = stall;
    start_req[c]++;
  endtask

  task automatic doReset();
    @(negedge clk);
    #2 rst_n = 1'b0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
  endtask

  task automatic waitTags(input int target, input int budget, input string name);
    int b = 0;
    while (n_tag < target && b < budget) begin @(negedge clk); b++; end
    @(negedge clk);
    checkOutput({name, " tag arrived"}, 32'(n_tag >= target), 32'd1);
  endtask

  task automatic waitAborts(input int target, input int budget, input string name);
    int b = 0;
    while (n_abort < target && b < budget) begin @(negedge clk); b++; end
    @(negedge clk);
    checkOutput({name, " abort arrived"}, 32'(n_abort >= target), 32'd1);
  endtask

  task automatic waitGrant(input int c, input int budget, input string name);
    int b = 0;
    while (!ch_gnt[c] && b < budget) begin @(negedge clk); b++; end
    checkOutput({name, " granted"}, 32'(ch_gnt[c]), 32'd1);
  endtask

  task automatic runTests();
    int bg, t0, a0, b;
    // Reset values, then srst drops one edge after release with no abort.
    @(negedge clk);
    checkOutput("rst srst", 32'(srst), 32'd1);
    checkOutput("rst gnt", 32'(ch_gnt), 32'd0);
    checkOutput("rst abort", 32'(abort), 32'd0);
    checkOutput("rst word_ch", 32'(word_ch), 32'd0);
    rst_n = 1'b1;
    @(posedge clk); #1;
    checkOutput("release srst", 32'(srst), 32'd0);
    checkOutput("release abort", 32'(abort), 32'd0);

    // Single ch2 word at full rate.
    @(negedge clk);
    bg = n_gnt; t0 = n_tag;
    applyStimulus(2, 16'hA5C3, 16'h0, 1, 1, -1, -1);
    b = 0;
    while (!ch_req[2] && b < 5) begin @(negedge clk); b++; end
    @(negedge clk);
    checkOutput("t1 req-to-gnt", 32'(ch_gnt), 32'h4);
    waitTags(t0 + 1, 40, "t1");
    checkOutput("t1 tag ch", 32'(last_tag_ch), 32'd2);
    checkOutput("t1 word", 32'(stub_word), 32'hA5C3);
    checkOutput("t1 gnt-to-tag", 32'(tag_cyc - gnt_cyc[bg]), 32'd17);

    // All four channels requesting; ch0 has two words.
    doReset();
    bg = n_gnt; t0 = n_tag;
    applyStimulus(0, 16'h1111, 16'h0F0F, 2, 1, -1, -1);
    applyStimulus(1, 16'h2222, 16'h0, 1, 1, -1, -1);
    applyStimulus(2, 16'h3333, 16'h0, 1, 1, -1, -1);
    applyStimulus(3, 16'h4444, 16'h0, 1, 1, -1, -1);
    waitTags(t0 + 5, 200, "t2");
    checkOutput("t2 order0", 32'(gnt_log[bg]), 32'd0);
    checkOutput("t2 order1", 32'(gnt_log[bg+1]), 32'd1);
    checkOutput("t2 order2", 32'(gnt_log[bg+2]), 32'd2);
    checkOutput("t2 order3", 32'(gnt_log[bg+3]), 32'd3);
    checkOutput("t2 order4", 32'(gnt_log[bg+4]), 32'd0);
    checkOutput("t2 last word", 32'(stub_word), 32'h0F0F);

    // ch1 stalls after 7 bits; ch0 and ch3 queue up behind it.
    doReset();
    bg = n_gnt; t0 = n_tag; a0 = n_abort;
    applyStimulus(1, 16'h00FF, 16'h0, 1, 1, -1, 7);
    waitGrant(1, 10, "t3");
    applyStimulus(0, 16'hBEEF, 16'h0, 1, 1, -1, -1);
    applyStimulus(3, 16'hCAFE, 16'h0, 1, 1, -1, -1);
    waitAborts(a0 + 1, 120, "t3");
    checkOutput("t3 abort ch", 32'(last_abort_ch), 32'd1);
    checkOutput("t3 abort time", 32'(abort_cyc - gnt_cyc[bg]), 32'd71);
    waitTags(t0 + 2, 100, "t3");
    checkOutput("t3 after1", 32'(gnt_log[bg+1]), 32'd3);
    checkOutput("t3 after2", 32'(gnt_log[bg+2]), 32'd0);

    // ch3 abandons its word after 10 bits.
    doReset();
    bg = n_gnt; t0 = n_tag; a0 = n_abort;
    applyStimulus(3, 16'h1234, 16'h0, 1, 1, 10, -1);
    waitAborts(a0 + 1, 60, "t4");
    checkOutput("t4 abort ch", 32'(last_abort_ch), 32'd3);
    checkOutput("t4 abort time", 32'(abort_cyc - gnt_cyc[bg]), 32'd11);
    repeat (10) @(negedge clk);
    checkOutput("t4 no tag", 32'(n_tag - t0), 32'd0);

    // Sparse valid, one bit in three cycles.
    doReset();
    bg = n_gnt; t0 = n_tag; a0 = n_abort;
    applyStimulus(0, 16'h5A3C, 16'h0, 1, 3, -1, -1);
    waitTags(t0 + 1, 200, "t5");
    checkOutput("t5 word", 32'(stub_word), 32'h5A3C);
    checkOutput("t5 tag ch", 32'(last_tag_ch), 32'd0);
    checkOutput("t5 no abort", 32'(n_abort - a0), 32'd0);
    checkOutput("t5 gnt-to-tag", 32'(tag_cyc - gnt_cyc[bg]), 32'd47);

    // Asynchronous reset in the middle of a ch0 word, then a clean ch0 word.
    doReset();
    t0 = n_tag;
    applyStimulus(0, 16'hC0DE, 16'h0, 1, 1, -1, -1);
    waitGrant(0, 10, "t6");
    repeat (5) @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    checkOutput("t6 async srst", 32'(srst), 32'd1);
    checkOutput("t6 async gnt", 32'(ch_gnt), 32'd0);
    checkOutput("t6 async data_val", 32'(d_val), 32'd0);
    checkOutput("t6 async abort", 32'(abort), 32'd0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk); #1;
    checkOutput("t6 release srst", 32'(srst), 32'd0);
    @(negedge clk);
    applyStimulus(0, 16'h0F5A, 16'h0, 1, 1, -1, -1);
    waitTags(t0 + 1, 60, "t6");
    checkOutput("t6 word", 32'(stub_word), 32'h0F5A);
    checkOutput("t6 tag count", 32'(n_tag - t0), 32'd1);

    // Deserializer never reports the word: flush after the idle limit.
    doReset();
    stub_mute = 1'b1;
    bg = n_gnt; t0 = n_tag; a0 = n_abort;
    applyStimulus(1, 16'h7777, 16'h0, 1, 1, -1, -1);
    waitAborts(a0 + 1, 150, "t7");
    checkOutput("t7 abort ch", 32'(last_abort_ch), 32'd1);
    checkOutput("t7 abort time", 32'(abort_cyc - gnt_cyc[bg]), 32'd80);
    checkOutput("t7 no tag", 32'(n_tag - t0), 32'd0);
    stub_mute = 1'b0;
    repeat (3) @(negedge clk);
  endtask

  initial begin
    fork
      compareLoop();
      runTests();
    join_any
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
